// File: rtl/axis_pkt_pkg.sv
// Shared widths, state encoding and length helpers for the AXI-Stream packet generator and queue.
package axis_pkt_pkg;
    localparam int C_DATA_WIDTH = 64;
    localparam int C_MTY_WIDTH  = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // A programmed length of 0 is sent as a single byte.
    function automatic int unsigned eff_len(input int unsigned len);
        return (len == 0) ? 1 : len;
    endfunction

    function automatic int unsigned calc_beats(input int unsigned len, input int unsigned lbytes);
        return (eff_len(len) + lbytes - 1) / lbytes;
    endfunction

    function automatic int unsigned calc_mty(input int unsigned len, input int unsigned lbytes);
        return calc_beats(len, lbytes) * lbytes - eff_len(len);
    endfunction
endpackage

// File: rtl/axis_pkt_payload.sv
// Lane-pattern generator: byte k of packet n is (n + k) mod 256, unused lanes are zero.
module axis_pkt_payload #(
    parameter int C_DATA_WIDTH = axis_pkt_pkg::C_DATA_WIDTH,
    parameter int C_LEN_WIDTH  = 16
) (
    input  logic [7:0]              pkt_idx,
    input  logic [C_LEN_WIDTH-1:0]  beat_idx,
    input  logic [C_LEN_WIDTH-1:0]  valid_bytes,
    output logic [C_DATA_WIDTH-1:0] data
);
    localparam int L_BYTES = C_DATA_WIDTH / 8;

    logic [7:0] base;

    always_comb begin
        base = pkt_idx + 8'(beat_idx * L_BYTES);
        data = '0;
        for (int j = 0; j < L_BYTES; j++) begin
            if (C_LEN_WIDTH'(j) < valid_bytes) begin
                data[8*j +: 8] = base + 8'(j);
            end
        end
    end
endmodule

// File: rtl/axis_pkt_gen.sv
// AXI-Stream test packet source with programmable length, count, gaps, stop and abort.
module axis_pkt_gen #(
    parameter int C_DATA_WIDTH = axis_pkt_pkg::C_DATA_WIDTH,
    parameter int C_MTY_WIDTH  = axis_pkt_pkg::C_MTY_WIDTH,
    parameter int C_LEN_WIDTH  = 16,
    parameter int C_CNT_WIDTH  = 16
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    cfg_start,
    input  logic [C_LEN_WIDTH-1:0]  cfg_len,
    input  logic [C_CNT_WIDTH-1:0]  cfg_pkt_cnt,
    input  logic [7:0]              cfg_gap,
    input  logic                    cfg_stop,
    input  logic                    cfg_abort,
    output logic                    busy,
    output logic [31:0]             pkts_sent,
    output logic                    m_axis_tvalid,
    output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tlast,
    output logic [C_MTY_WIDTH-1:0]  m_axis_tuser_mty,
    input  logic                    m_axis_tready,
    output logic                    drop_incmpt_pkt
);
    import axis_pkt_pkg::*;

    localparam int L_BYTES = C_DATA_WIDTH / 8;

    logic [1:0]              state, state_nxt;
    logic [C_LEN_WIDTH-1:0]  len_r, beat_idx;
    logic [C_CNT_WIDTH-1:0]  cnt_r, sent_in_run;
    logic [7:0]              gap_r, gap_cnt, pkt_idx;
    logic                    stop_pend, mid_pkt;

    logic                    xfer, last_xfer, start, abort, stop_now, run_done;
    logic                    load, clear, nxt_last;
    logic [C_LEN_WIDTH-1:0]  sel_len, last_beat, nxt_beat, nxt_valid;
    logic [C_MTY_WIDTH-1:0]  sel_mty;
    logic [7:0]              nxt_pkt;
    logic [C_DATA_WIDTH-1:0] nxt_data;

    assign xfer      = m_axis_tvalid && m_axis_tready;
    assign last_xfer = xfer && m_axis_tlast;
    assign start     = (state == ST_IDLE) && cfg_start && !cfg_abort;
    assign abort     = (state != ST_IDLE) && cfg_abort;
    assign stop_now  = stop_pend || cfg_stop;
    assign run_done  = (cnt_r != '0) && (sent_in_run + C_CNT_WIDTH'(1) == cnt_r);

    // In IDLE the first beat is built straight from cfg_len, before it is latched.
    assign sel_len   = (state == ST_IDLE) ? cfg_len : len_r;
    assign last_beat = C_LEN_WIDTH'(calc_beats(32'(sel_len), L_BYTES) - 1);
    assign sel_mty   = C_MTY_WIDTH'(calc_mty(32'(sel_len), L_BYTES));
    assign nxt_pkt   = (state == ST_IDLE) ? 8'd0 : (last_xfer ? pkt_idx + 8'd1 : pkt_idx);
    assign nxt_beat  = (state == ST_SEND && !last_xfer) ? beat_idx + C_LEN_WIDTH'(1) : '0;
    assign nxt_last  = (nxt_beat == last_beat);
    assign nxt_valid = nxt_last ? C_LEN_WIDTH'(L_BYTES) - C_LEN_WIDTH'(sel_mty)
                                : C_LEN_WIDTH'(L_BYTES);

    axis_pkt_payload #(
        .C_DATA_WIDTH (C_DATA_WIDTH),
        .C_LEN_WIDTH  (C_LEN_WIDTH)
    ) u_payload (
        .pkt_idx     (nxt_pkt),
        .beat_idx    (nxt_beat),
        .valid_bytes (nxt_valid),
        .data        (nxt_data)
    );

    // load presents a fresh beat on the output registers; clear drops the stream to idle.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        clear     = 1'b0;
        if (abort) begin
            state_nxt = ST_IDLE;
            clear     = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_nxt = ST_SEND;
                        load      = 1'b1;
                    end
                end
                ST_SEND: begin
                    if (last_xfer) begin
                        if (stop_now || run_done) begin
                            state_nxt = ST_IDLE;
                            clear     = 1'b1;
                        end else if (gap_r != 8'd0) begin
                            state_nxt = ST_GAP;
                            clear     = 1'b1;
                        end else begin
                            load = 1'b1;
                        end
                    end else if (xfer) begin
                        load = 1'b1;
                    end
                end
                ST_GAP: begin
                    if (stop_now) begin
                        state_nxt = ST_IDLE;
                    end else if (gap_cnt == 8'd1) begin
                        state_nxt = ST_SEND;
                        load      = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    clear     = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state            <= ST_IDLE;
            busy             <= 1'b0;
            pkts_sent        <= '0;
            drop_incmpt_pkt  <= 1'b0;
            m_axis_tvalid    <= 1'b0;
            m_axis_tdata     <= '0;
            m_axis_tlast     <= 1'b0;
            m_axis_tuser_mty <= '0;
            len_r            <= '0;
            beat_idx         <= '0;
            cnt_r            <= '0;
            sent_in_run      <= '0;
            gap_r            <= '0;
            gap_cnt          <= '0;
            pkt_idx          <= '0;
            stop_pend        <= 1'b0;
            mid_pkt          <= 1'b0;
        end else begin
            state           <= state_nxt;
            busy            <= (state_nxt != ST_IDLE);
            drop_incmpt_pkt <= abort && (mid_pkt || xfer) && !last_xfer;
            if (last_xfer) begin
                pkts_sent <= pkts_sent + 32'd1;
            end

            if (start) begin
                len_r       <= cfg_len;
                cnt_r       <= cfg_pkt_cnt;
                gap_r       <= cfg_gap;
                sent_in_run <= '0;
                pkt_idx     <= '0;
            end else if (last_xfer) begin
                sent_in_run <= sent_in_run + C_CNT_WIDTH'(1);
                pkt_idx     <= pkt_idx + 8'd1;
            end

            if (load) begin
                m_axis_tvalid    <= 1'b1;
                m_axis_tdata     <= nxt_data;
                m_axis_tlast     <= nxt_last;
                m_axis_tuser_mty <= nxt_last ? sel_mty : '0;
                beat_idx         <= nxt_beat;
            end else if (clear) begin
                m_axis_tvalid    <= 1'b0;
                m_axis_tdata     <= '0;
                m_axis_tlast     <= 1'b0;
                m_axis_tuser_mty <= '0;
            end

            if (state == ST_SEND && state_nxt == ST_GAP) begin
                gap_cnt <= gap_r;
            end else if (state == ST_GAP) begin
                gap_cnt <= gap_cnt - 8'd1;
            end

            if (state_nxt == ST_IDLE) begin
                stop_pend <= 1'b0;
            end else if (cfg_stop && state != ST_IDLE) begin
                stop_pend <= 1'b1;
            end

            if (start || last_xfer || abort) begin
                mid_pkt <= 1'b0;
            end else if (xfer) begin
                mid_pkt <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_axis_pkt_gen.sv
// Randomized bench for axis_pkt_gen; expected beats come from a byte-level model of each packet.
module tb_axis_pkt_gen;
    localparam int DW = 64;
    localparam int L  = DW / 8;
    localparam int MW = 3;
    localparam int LW = 16;
    localparam int CW = 16;

    logic          aclk          = 1'b0;
    logic          aresetn       = 1'b0;
    logic          cfg_start     = 1'b0;
    logic          cfg_stop      = 1'b0;
    logic          cfg_abort     = 1'b0;
    logic          m_axis_tready = 1'b0;
    logic [LW-1:0] cfg_len       = '0;
    logic [CW-1:0] cfg_pkt_cnt   = '0;
    logic [7:0]    cfg_gap       = '0;

    logic          busy, m_axis_tvalid, m_axis_tlast, drop_incmpt_pkt;
    logic [31:0]   pkts_sent;
    logic [DW-1:0] m_axis_tdata;
    logic [MW-1:0] m_axis_tuser_mty;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_pkts = '0;
    int          ready_pat[$];

    always #5 aclk = ~aclk;

    axis_pkt_gen #(
        .C_DATA_WIDTH (DW),
        .C_MTY_WIDTH  (MW),
        .C_LEN_WIDTH  (LW),
        .C_CNT_WIDTH  (CW)
    ) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .cfg_start        (cfg_start),
        .cfg_len          (cfg_len),
        .cfg_pkt_cnt      (cfg_pkt_cnt),
        .cfg_gap          (cfg_gap),
        .cfg_stop         (cfg_stop),
        .cfg_abort        (cfg_abort),
        .busy             (busy),
        .pkts_sent        (pkts_sent),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tuser_mty (m_axis_tuser_mty),
        .m_axis_tready    (m_axis_tready),
        .drop_incmpt_pkt  (drop_incmpt_pkt)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Beat starting at byte offset k of packet n: byte value is (n + byte) mod 256.
    function automatic logic [DW-1:0] expBeat(input int n, input int k, input int len);
        logic [DW-1:0] d;
        d = '0;
        for (int j = 0; j < L; j++) begin
            if (k + j < len) d[8*j +: 8] = 8'((n + k + j) % 256);
        end
        return d;
    endfunction

    task automatic applyStimulus(input int len, input int cnt, input int gap, input int pct,
                                 input int stop_at, input int abort_at, input int reset_at);
        int eff, n, k, sent, gap_left, cyc, mode;
        bit done, stop_p, exp_valid, rdy, xfer, last, exp_drop;
        eff = (len == 0) ? 1 : len;
        n = 0; k = 0; sent = 0; gap_left = 0; cyc = 0; mode = 0;
        done = 1'b0; stop_p = 1'b0; exp_drop = 1'b0;
        @(negedge aclk);
        cfg_len = LW'(len); cfg_pkt_cnt = CW'(cnt); cfg_gap = 8'(gap); cfg_start = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        while (!done && cyc < 4000) begin
            exp_valid = (gap_left == 0);
            checkOutput("tvalid", 64'(m_axis_tvalid), 64'(exp_valid));
            if (exp_valid) begin
                last = (k + L >= eff);
                checkOutput("tdata", 64'(m_axis_tdata), 64'(expBeat(n, k, eff)));
                checkOutput("tlast", 64'(m_axis_tlast), 64'(last));
                checkOutput("tuser_mty", 64'(m_axis_tuser_mty), last ? 64'(k + L - eff) : 64'd0);
            end
            checkOutput("busy", 64'(busy), 64'd1);
            checkOutput("drop_quiet", 64'(drop_incmpt_pkt), 64'd0);
            checkOutput("pkts_sent", 64'(pkts_sent), 64'(exp_pkts));

            if (ready_pat.size() > 0) rdy = (ready_pat.pop_front() != 0);
            else rdy = ($urandom_range(99, 0) < pct);
            m_axis_tready = rdy;
            cfg_stop    = (cyc == stop_at);
            cfg_abort   = (cyc == abort_at);
            aresetn     = (cyc != reset_at);
            cfg_start   = ($urandom_range(15, 0) == 0);
            cfg_len     = LW'($urandom);
            cfg_pkt_cnt = CW'($urandom);
            cfg_gap     = 8'($urandom);

            if (cyc == stop_at) stop_p = 1'b1;
            xfer     = exp_valid && rdy;
            last     = xfer && (k + L >= eff);
            exp_drop = (k > 0 || xfer) && !last;
            if (cyc == reset_at) begin
                exp_pkts = '0; done = 1'b1; mode = 2;
            end else begin
                if (last) begin
                    exp_pkts++; sent++;
                end
                if (cyc == abort_at) begin
                    done = 1'b1; mode = 1;
                end else if (last) begin
                    n++; k = 0;
                    if (stop_p || (cnt != 0 && sent == cnt)) done = 1'b1;
                    else gap_left = gap;
                end else if (xfer) begin
                    k += L;
                end else if (!exp_valid) begin
                    if (stop_p) done = 1'b1;
                    else gap_left--;
                end
            end
            @(posedge aclk);
            @(negedge aclk);
            cyc++;
        end
        cfg_start = 1'b0; cfg_stop = 1'b0; cfg_abort = 1'b0; aresetn = 1'b1;
        checkOutput("end_tvalid", 64'(m_axis_tvalid), 64'd0);
        checkOutput("end_busy", 64'(busy), 64'd0);
        checkOutput("end_drop", 64'(drop_incmpt_pkt), (mode == 1) ? 64'(exp_drop) : 64'd0);
        checkOutput("end_pkts", 64'(pkts_sent), 64'(exp_pkts));
        if (mode == 2) begin
            checkOutput("rst_tdata", 64'(m_axis_tdata), 64'd0);
            checkOutput("rst_tlast", 64'(m_axis_tlast), 64'd0);
            checkOutput("rst_mty", 64'(m_axis_tuser_mty), 64'd0);
        end
        @(posedge aclk);
        @(negedge aclk);
        checkOutput("drop_single", 64'(drop_incmpt_pkt), 64'd0);
        checkOutput("idle_tvalid", 64'(m_axis_tvalid), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checkOutput("rst_valid", 64'(m_axis_tvalid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_pkts", 64'(pkts_sent), 64'd0);
        checkOutput("rst_drop", 64'(drop_incmpt_pkt), 64'd0);
        checkOutput("rst_data", 64'(m_axis_tdata), 64'd0);
        aresetn = 1'b1;

        applyStimulus(20, 1, 0, 100, -1, -1, -1);
        ready_pat = '{1, 0, 0, 1, 1};
        applyStimulus(20, 1, 0, 100, -1, -1, -1);
        applyStimulus(8, 3, 2, 100, -1, -1, -1);
        ready_pat = '{1, 1, 0};
        applyStimulus(32, 1, 0, 100, -1, 2, -1);
        applyStimulus(8, 5, 4, 100, -1, 2, -1);
        applyStimulus(40, 0, 0, 100, 7, -1, -1);
        applyStimulus(0, 2, 1, 100, -1, -1, -1);

        // start together with abort while idle must not launch a run
        @(negedge aclk);
        cfg_len = 16'd8; cfg_pkt_cnt = 16'd1; cfg_start = 1'b1; cfg_abort = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        cfg_start = 1'b0; cfg_abort = 1'b0;
        checkOutput("idle_abort_valid", 64'(m_axis_tvalid), 64'd0);
        checkOutput("idle_abort_busy", 64'(busy), 64'd0);

        applyStimulus(12, 0, 0, 100, -1, -1, 9);
        applyStimulus(12, 2, 1, 70, -1, -1, -1);

        for (int r = 0; r < 25; r++) begin
            int ev, at;
            ev = int'($urandom_range(5, 0));
            at = int'($urandom_range(25, 0));
            applyStimulus(int'($urandom_range(100, 0)), int'($urandom_range(4, 1)),
                          int'($urandom_range(3, 0)), int'($urandom_range(100, 40)),
                          (ev == 1) ? at : -1, (ev == 2) ? at : -1, (ev == 3) ? at : -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
